alu_issue_arbiter: RTL and testbench

- Shares one multi-cycle ALU execution unit between NREQ requesters.
- Picks a requester by round-robin and latches its opcode and operands.
- Drives the execution sequencer with a one-cycle start pulse, waits for its done pulse, then returns the result to the winner with a valid/ready handshake.
- A watchdog aborts a transaction whose done pulse never arrives.

---
 rtl/alu_issue_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU sequencer between NREQ requesters.
// Latches the winner's operands, pulses start, waits for done (with watchdog), returns the result.
module alu_issue_arbiter #(
    parameter int NREQ    = 4,
    parameter int OP_W    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*OP_W-1:0]   req_op,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   alu_start,
    output logic [OP_W-1:0]        alu_op,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    input  logic                   alu_done,
    input  logic [DATA_W-1:0]      alu_result,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [DATA_W-1:0]      resp_result,
    output logic                   resp_err,
    output logic                   busy
);
    localparam int TM_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, winner_q;
    logic [TM_W-1:0]   timer_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [ID_W-1:0]   id_q;
    logic              err_q;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   scan_idx;
    logic              timeout_hit;

    assign timeout_hit = (timer_q == TM_W'(TIMEOUT - 1));

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + i) % NREQ);
            if (req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (alu_done || timeout_hit) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is the only Mealy output; gated so it stays low during reset.
    always_comb begin
        req_ready  = '0;
        alu_start  = 1'b0;
        resp_valid = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE:    if (grant_vld && !reset) req_ready[grant_id] = 1'b1;
            ISSUE:   alu_start = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            winner_q <= '0;
            timer_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (grant_vld) begin
                    winner_q <= grant_id;
                    op_q     <= req_op[grant_id*OP_W +: OP_W];
                    a_q      <= req_a[grant_id*DATA_W +: DATA_W];
                    b_q      <= req_b[grant_id*DATA_W +: DATA_W];
                end
                ISSUE: timer_q <= '0;
                WAIT: begin
                    // done has priority over the watchdog when both land together
                    if (alu_done) begin
                        res_q <= alu_result;
                        id_q  <= winner_q;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_q <= '0;
                        id_q  <= winner_q;
                        err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: if (resp_ready)
                    rr_ptr_q <= (winner_q == ID_W'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: grant order, latency, watchdog, backpressure, mid-op reset.
module tb_alu_issue_arbiter;
    localparam int NREQ = 4, OP_W = 4, DATA_W = 8, TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*OP_W-1:0]   req_op;
    logic [NREQ*DATA_W-1:0] req_a, req_b;
    logic [NREQ-1:0]        req_ready;
    logic                   alu_start, alu_done, resp_valid, resp_ready, resp_err, busy;
    logic [OP_W-1:0]        alu_op;
    logic [DATA_W-1:0]      alu_a, alu_b, alu_result, resp_result;
    logic [1:0]             resp_id;

    logic [OP_W-1:0]   op_tbl [NREQ];
    logic [DATA_W-1:0] a_tbl  [NREQ];
    logic [DATA_W-1:0] b_tbl  [NREQ];

    int n_checks = 0;
    int n_errors = 0;

    assign req_op = {op_tbl[3], op_tbl[2], op_tbl[1], op_tbl[0]};
    assign req_a  = {a_tbl[3], a_tbl[2], a_tbl[1], a_tbl[0]};
    assign req_b  = {b_tbl[3], b_tbl[2], b_tbl[1], b_tbl[0]};

    always #5 clk = ~clk;

    alu_issue_arbiter #(.NREQ(NREQ), .OP_W(OP_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts in IDLE just after a rising edge. done_cyc: cycle (accept = 0) of the done pulse, 0 = never.
    task automatic txn(input string tag, input logic [3:0] vld, input int exp_id, input int done_cyc,
                       input logic [7:0] res, input int exp_lat, input logic [7:0] exp_res,
                       input logic exp_err);
        int   lat;
        logic extra_start;
        req_valid = vld;
        @(negedge clk);
        check({tag, ":ready"}, 32'(req_ready), 32'(4'b0001 << exp_id));
        check({tag, ":start0"}, 32'(alu_start), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, ":start1"}, 32'(alu_start), 32'(1));
        check({tag, ":opab"}, {12'h0, alu_op, alu_a, alu_b},
              {12'h0, op_tbl[exp_id], a_tbl[exp_id], b_tbl[exp_id]});
        lat = 0;
        extra_start = 1'b0;
        for (int cyc = 2; cyc < 60 && lat == 0; cyc++) begin
            @(posedge clk); #1;
            alu_done   = (cyc == done_cyc);
            alu_result = alu_done ? res : 8'h00;
            @(negedge clk);
            if (alu_start) extra_start = 1'b1;
            if (resp_valid) lat = cyc;
        end
        alu_done = 1'b0;
        check({tag, ":start_once"}, 32'(extra_start), 32'(0));
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":resp"}, {21'h0, resp_id, resp_err, resp_result},
              {21'h0, 2'(exp_id), exp_err, exp_res});
        if (resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        op_tbl[0] = 4'h3; a_tbl[0] = 8'h12; b_tbl[0] = 8'h05;
        op_tbl[1] = 4'h5; a_tbl[1] = 8'h21; b_tbl[1] = 8'h31;
        op_tbl[2] = 4'h9; a_tbl[2] = 8'h40; b_tbl[2] = 8'h07;
        op_tbl[3] = 4'hC; a_tbl[3] = 8'h7F; b_tbl[3] = 8'h80;
        reset      = 1'b1;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        alu_done   = 1'b0;
        alu_result = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_ctl", {26'h0, req_ready, busy, alu_start}, 32'h0);
        check("rst_resp", {20'h0, resp_valid, resp_err, resp_id, resp_result}, 32'h0);
        check("rst_alu", {12'h0, alu_op, alu_a, alu_b}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        check("idle_noreq", {27'h0, req_ready, busy}, 32'h0);
        @(posedge clk); #1;

        txn("single", 4'b0001, 0, 2, 8'h17, 3, 8'h17, 1'b0);

        reset = 1'b1;
        req_valid = 4'h0;
        @(posedge clk); #1;
        reset = 1'b0;

        for (int k = 0; k < 8; k++)
            txn("rr", 4'hF, k % 4, 2, 8'(8'h10 + k), 3, 8'(8'h10 + k), 1'b0);

        txn("skip1", 4'b0010, 1, 2, 8'h21, 3, 8'h21, 1'b0);
        txn("skip0", 4'b0011, 0, 2, 8'h22, 3, 8'h22, 1'b0);

        txn("tmo", 4'b0100, 2, 0, 8'h00, 18, 8'h00, 1'b1);
        txn("tie", 4'b1000, 3, 17, 8'hAA, 18, 8'hAA, 1'b0);

        resp_ready = 1'b0;
        txn("bp", 4'b0100, 2, 2, 8'h5A, 3, 8'h5A, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            alu_done   = 1'b1;
            alu_result = 8'hFF;
            req_valid  = 4'hF;
            @(negedge clk);
            check("bp_hold", {17'h0, resp_valid, resp_id, resp_err, resp_result, req_ready},
                  {17'h0, 1'b1, 2'd2, 1'b0, 8'h5A, 4'b0000});
        end
        @(posedge clk); #1;
        alu_done   = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 4'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release", {30'h0, busy, resp_valid}, 32'h0);

        req_valid = 4'b1000;
        #1;
        check("pre_rst_ready", 32'(req_ready), 32'(4'b1000));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("midrst_ctl", {26'h0, req_ready, busy, resp_valid}, 32'h0);
        check("midrst_data", {9'h0, alu_start, alu_op, alu_a, resp_err, resp_id, resp_result}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 4'h0;

        txn("post_rst", 4'b1100, 2, 2, 8'h3C, 3, 8'h3C, 1'b0);
        req_valid = 4'h0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
